// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder.
//   ADD_WIDTH_DEFAULT : default operand/result width in bits
//   state_e           : sequencer states (IDLE waits for operands,
//                       RUN adds one bit per clock, DONE holds the result)
package serial_add_pkg;

  localparam int ADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/full_add_cell.sv
// full_add_cell
// One-bit combinational full adder, the datapath of the serial adder.
// Ports:
//   a, b : input  addend bits
//   ci   : input  carry in
//   s    : output sum bit
//   co   : output carry out
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic halfSum;

  assign halfSum = a ^ b;
  assign s       = halfSum ^ ci;
  assign co      = (a & b) | (halfSum & ci);

endmodule : full_add_cell

// File: rtl/serial_add_seq.sv
// serial_add_seq
// Bit-serial adder: accepts an operand set with a valid/ready handshake,
// adds one bit per clock through a single full-adder cell, then presents
// {cout,sum} = op_a + op_b + cin until the consumer accepts it.
// Ports:
//   clk       : input  clock, rising edge active
//   rst_n     : input  asynchronous active-low reset
//   in_valid  : input  operand set present on op_a/op_b/cin
//   in_ready  : output block can accept an operand set (state IDLE)
//   op_a,op_b : input  WIDTH-bit addends
//   cin       : input  carry into the LSB
//   out_valid : output sum/cout hold a completed result (state DONE)
//   out_ready : input  consumer accepts the result
//   sum       : output WIDTH-bit sum modulo 2^WIDTH
//   cout      : output carry out of bit WIDTH-1
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic cellSum;
  logic cellCarry;

  full_add_cell uCell (
    .a  (aShift_q[0]),
    .b  (bShift_q[0]),
    .ci (carry_q),
    .s  (cellSum),
    .co (cellCarry)
  );

  // State and datapath registers. Reset clears everything so the outputs
  // are defined immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic. Operands are only sampled in IDLE, so the inputs are
  // free to change while a sum is in flight. In RUN each new sum bit enters
  // at the MSB end; after WIDTH shifts bit 0 has reached the LSB. The carry
  // flop doubles as cout once the last bit has been processed.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          aShift_d = op_a;
          bShift_d = op_b;
          carry_d  = cin;
          result_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = {cellSum, result_q[WIDTH-1:1]};
        carry_d  = cellCarry;
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = result_q;
  assign cout      = carry_q;

endmodule : serial_add_seq
